// File: rtl/writeback_unit_l2.sv
// ============================================================================
// Module   : writeback_unit_l2
// Brief    : X->W writeback stage; round-robin merge of execute-unit results
//            into one registered register-file write port and ROB completion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_unit_l2 #(
    parameter int p_num_pipes    = 2,
    parameter int p_seq_num_bits = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [p_num_pipes-1:0]                X_val,
    output logic [p_num_pipes-1:0]                X_rdy,
    input  logic [p_num_pipes*32-1:0]             X_pc,
    input  logic [p_num_pipes*p_seq_num_bits-1:0] X_seq_num,
    input  logic [p_num_pipes*5-1:0]              X_waddr,
    input  logic [p_num_pipes*32-1:0]             X_wdata,
    input  logic [p_num_pipes-1:0]                X_wen,
    output logic                                  rf_wen,
    output logic [4:0]                            rf_waddr,
    output logic [31:0]                           rf_wdata,
    output logic                                  complete_val,
    output logic [31:0]                           complete_pc,
    output logic [p_seq_num_bits-1:0]             complete_seq_num
);

    localparam int c_PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    logic [c_PTR_W-1:0]        r_ptr;
    logic [c_PTR_W-1:0]        w_ptr_nxt;
    logic [p_num_pipes-1:0]    w_grant;
    logic                      w_any;
    logic                      w_xfer;
    logic [c_PTR_W-1:0]        w_gidx;
    logic [31:0]               w_sel_pc;
    logic [p_seq_num_bits-1:0] w_sel_seq;
    logic [4:0]                w_sel_waddr;
    logic [31:0]               w_sel_wdata;
    logic                      w_sel_wen;

    logic                      r_val;
    logic [c_PTR_W-1:0]        r_idx;
    logic [31:0]               r_pc;
    logic [p_seq_num_bits-1:0] r_seq;
    logic [4:0]                r_waddr;
    logic [31:0]               r_wdata;
    logic                      r_wen;

    // Scan offsets from the pointer outward; the first valid input wins.
    always_comb begin
        w_grant     = '0;
        w_any       = 1'b0;
        w_gidx      = '0;
        w_sel_pc    = '0;
        w_sel_seq   = '0;
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        w_sel_wen   = 1'b0;
        for (int k = 0; k < p_num_pipes; k++) begin
            for (int i = 0; i < p_num_pipes; i++) begin
                if (!w_any && X_val[i] && ((int'(r_ptr) + k) % p_num_pipes) == i) begin
                    w_any       = 1'b1;
                    w_grant[i]  = 1'b1;
                    w_gidx      = c_PTR_W'(i);
                    w_sel_pc    = X_pc[i*32 +: 32];
                    w_sel_seq   = X_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
                    w_sel_waddr = X_waddr[i*5 +: 5];
                    w_sel_wdata = X_wdata[i*32 +: 32];
                    w_sel_wen   = X_wen[i];
                end
            end
        end
    end

    assign X_rdy  = rst ? '0 : w_grant;
    assign w_xfer = w_any && !rst;

    assign w_ptr_nxt = (w_gidx == c_PTR_W'(p_num_pipes - 1)) ? '0 : w_gidx + c_PTR_W'(1);

    generate
        if (p_num_pipes > 1) begin : g_ptr_rr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end else begin : g_ptr_fixed
            assign r_ptr = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= 1'b0;
            r_idx   <= '0;
            r_pc    <= '0;
            r_seq   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
        end else begin
            r_val <= w_xfer;
            // Payload holds across idle cycles; only r_val qualifies it.
            if (w_xfer) begin
                r_idx   <= w_gidx;
                r_pc    <= w_sel_pc;
                r_seq   <= w_sel_seq;
                r_waddr <= w_sel_waddr;
                r_wdata <= w_sel_wdata;
                r_wen   <= w_sel_wen;
            end
        end
    end

    assign rf_wen           = r_val && r_wen && (r_waddr != 5'd0);
    assign rf_waddr         = r_waddr;
    assign rf_wdata         = r_wdata;
    assign complete_val     = r_val;
    assign complete_pc      = r_pc;
    assign complete_seq_num = r_seq;

    // Debug view: {valid, granted input, destination, data}; zero when idle.
    function automatic logic [c_PTR_W+37:0] trace();
        return r_val ? {1'b1, r_idx, r_waddr, r_wdata} : '0;
    endfunction

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit_l2.sv
// ============================================================================
// Module   : tb_writeback_unit_l2
// Brief    : Scoreboard bench for writeback_unit_l2 with three execute sources.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit_l2;

    localparam int c_N  = 3;
    localparam int c_SB = 5;

    typedef struct {
        logic [31:0]     pc;
        logic [c_SB-1:0] seq;
        logic [4:0]      waddr;
        logic [31:0]     wdata;
        logic            wen;
    } msg_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [c_N-1:0]       X_val;
    logic [c_N-1:0]       X_rdy;
    logic [c_N*32-1:0]    X_pc;
    logic [c_N*c_SB-1:0]  X_seq_num;
    logic [c_N*5-1:0]     X_waddr;
    logic [c_N*32-1:0]    X_wdata;
    logic [c_N-1:0]       X_wen;
    logic                 rf_wen;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 complete_val;
    logic [31:0]          complete_pc;
    logic [c_SB-1:0]      complete_seq_num;

    writeback_unit_l2 #(.p_num_pipes(c_N), .p_seq_num_bits(c_SB)) dut (
        .clk(clk), .rst(rst),
        .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
        .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .complete_val(complete_val), .complete_pc(complete_pc),
        .complete_seq_num(complete_seq_num)
    );

    always #5 clk = ~clk;

    msg_t src_q[c_N][$];
    msg_t cur_m[c_N];
    logic cur_v[c_N];
    int   gap[c_N];
    bit   rand_gaps;
    msg_t exp_q[$];
    int   m_ptr;
    int   n_tests;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < c_N; i++) begin
            X_val[i]                 = cur_v[i];
            X_pc[i*32 +: 32]         = cur_m[i].pc;
            X_seq_num[i*c_SB +: c_SB] = cur_m[i].seq;
            X_waddr[i*5 +: 5]        = cur_m[i].waddr;
            X_wdata[i*32 +: 32]      = cur_m[i].wdata;
            X_wen[i]                 = cur_m[i].wen;
        end
    endtask

    // Sources present their next message once idle and any gap has elapsed.
    task automatic refill();
        for (int i = 0; i < c_N; i++) begin
            if (!cur_v[i]) begin
                if (gap[i] > 0) gap[i]--;
                else if (src_q[i].size() > 0) begin
                    cur_m[i] = src_q[i].pop_front();
                    cur_v[i] = 1'b1;
                end
            end
        end
        drive();
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < c_N; i++)
            if (src_q[i].size() > 0 || cur_v[i] || gap[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic cycle();
        logic [c_N-1:0] eg, rdy_s, val_s;
        bit             xfer;
        msg_t           e;
        @(negedge clk);
        eg = '0;
        for (int k = 0; k < c_N; k++) begin
            int idx = (m_ptr + k) % c_N;
            if (eg == '0 && X_val[idx]) eg[idx] = 1'b1;
        end
        check_eq("x_rdy", X_rdy, eg);
        rdy_s = X_rdy;
        val_s = X_val;
        @(posedge clk);
        #1;
        xfer = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            if (val_s[i] && rdy_s[i]) begin
                exp_q.push_back(cur_m[i]);
                cur_v[i] = 1'b0;
                gap[i]   = rand_gaps ? int'($urandom_range(0, 3)) : 0;
                m_ptr    = (i + 1) % c_N;
                xfer     = 1'b1;
            end
        end
        check_eq("complete_val", complete_val, xfer);
        if (xfer) begin
            e = exp_q.pop_front();
            check_eq("complete_pc", complete_pc, e.pc);
            check_eq("complete_seq", complete_seq_num, e.seq);
            check_eq("rf_waddr", rf_waddr, e.waddr);
            check_eq("rf_wdata", rf_wdata, e.wdata);
            check_eq("rf_wen", rf_wen, e.wen && (e.waddr != 5'd0));
        end else begin
            check_eq("rf_wen_idle", rf_wen, 1'b0);
        end
        refill();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (pending() && n < max_cycles) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", pending(), 1'b0);
        cycle();
    endtask

    function automatic msg_t mk(input logic [31:0] pc, input logic [4:0] seq,
                                input logic [4:0] wa, input logic [31:0] wd, input logic we);
        msg_t m;
        m.pc = pc; m.seq = seq; m.waddr = wa; m.wdata = wd; m.wen = we;
        return m;
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_ptr     = 0;
        rand_gaps = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            cur_v[i] = 1'b0;
            gap[i]   = 0;
            cur_m[i] = mk(32'h0, 5'h0, 5'h0, 32'h0, 1'b0);
        end
        rst = 1'b1;
        drive();

        // Reset state
        #12;
        check_eq("rst_complete_val", complete_val, 1'b0);
        check_eq("rst_rf_wen", rf_wen, 1'b0);
        check_eq("rst_rf_waddr", rf_waddr, 5'd0);
        check_eq("rst_rf_wdata", rf_wdata, 32'd0);
        check_eq("rst_complete_pc", complete_pc, 32'd0);
        check_eq("rst_complete_seq", complete_seq_num, 5'd0);
        X_val = 3'b111;
        #1;
        check_eq("rst_x_rdy", X_rdy, 3'b000);
        drive();
        @(posedge clk);
        #2 rst = 1'b0;

        // Single input
        src_q[0].push_back(mk(32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1));
        refill();
        drain(20);

        // Contention between inputs 0 and 1
        for (int j = 0; j < 4; j++) begin
            src_q[0].push_back(mk(32'h1000 + 4*j, 5'(j), 5'(j + 1), 32'hA000 + j, 1'b1));
            src_q[1].push_back(mk(32'h2000 + 4*j, 5'(j + 8), 5'(j + 10), 32'hB000 + j, 1'b1));
        end
        refill();
        drain(30);

        // x0 and wen=0 suppression
        src_q[0].push_back(mk(32'h300, 5'd1, 5'd0, 32'h1234, 1'b1));
        src_q[0].push_back(mk(32'h304, 5'd2, 5'd7, 32'h5678, 1'b0));
        refill();
        drain(20);

        // Pointer hold across idle cycles
        src_q[1].push_back(mk(32'h400, 5'd4, 5'd9, 32'h4444, 1'b1));
        refill();
        cycle();
        cycle();
        cycle();
        src_q[0].push_back(mk(32'h500, 5'd5, 5'd11, 32'h5555, 1'b1));
        src_q[1].push_back(mk(32'h600, 5'd6, 5'd12, 32'h6666, 1'b1));
        refill();
        #1;
        check_eq("hold_grant", X_rdy, 3'b001);
        drain(20);

        // Asynchronous reset mid-stream
        for (int j = 0; j < 4; j++) begin
            src_q[0].push_back(mk(32'h700 + 4*j, 5'(j + 16), 5'(j + 3), 32'hC000 + j, 1'b1));
            src_q[1].push_back(mk(32'h800 + 4*j, 5'(j + 20), 5'(j + 13), 32'hD000 + j, 1'b1));
        end
        refill();
        cycle();
        #2 rst = 1'b1;
        m_ptr = 0;
        #1;
        check_eq("arst_complete_val", complete_val, 1'b0);
        check_eq("arst_rf_wen", rf_wen, 1'b0);
        check_eq("arst_x_rdy", X_rdy, 3'b000);
        @(posedge clk);
        #1;
        check_eq("arst_edge_rf_wen", rf_wen, 1'b0);
        check_eq("arst_edge_complete_val", complete_val, 1'b0);
        #1 rst = 1'b0;
        #1;
        check_eq("arst_tie_grant", X_rdy, 3'b001);
        drain(30);

        // Random valid gaps on all three inputs
        rand_gaps = 1'b1;
        for (int i = 0; i < c_N; i++) begin
            for (int j = 0; j < 8; j++) begin
                src_q[i].push_back(mk($urandom, 5'(i*8 + j), 5'($urandom_range(0, 31)),
                                      $urandom, 1'($urandom_range(0, 1))));
            end
        end
        refill();
        drain(400);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/writeback_unit_l2.md
# writeback_unit_l2

Writeback stage that terminates the X→W boundary. It accepts completed results from `p_num_pipes` execute units, such as the ALU and the pipelined multiplier, over valid/ready `X__WIntf`-style channels. A round-robin arbiter picks one result per cycle. The chosen result is registered and drives one register-file write port plus a completion report to the scoreboard/ROB.

## Interface
Parameters:
- `p_num_pipes`, 2: number of execute-unit inputs; legal range 1–8.
- `p_seq_num_bits`, 5: width of the sequence number.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `X_val`  in  `p_num_pipes`  per-input valid.
- `X_rdy`  out  `p_num_pipes`  per-input ready; one-hot or zero.
- `X_pc`  in  `p_num_pipes`×32  per-input PC.
- `X_seq_num`  in  `p_num_pipes`×`p_seq_num_bits`  per-input sequence number.
- `X_waddr`  in  `p_num_pipes`×5  per-input destination register.
- `X_wdata`  in  `p_num_pipes`×32  per-input result.
- `X_wen`  in  `p_num_pipes`  per-input write enable.
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `complete_val`  out  1  an instruction retired from X this cycle.
- `complete_pc`  out  32  PC of the retiring instruction.
- `complete_seq_num`  out  `p_seq_num_bits`  sequence number of the retiring instruction.

## Operation
- **Arbitration:**
  - Combinational round-robin over `X_val`.
  - The priority pointer `ptr` (clog2 of `p_num_pipes` bits) names the highest-priority input.
  - The grant goes to the first asserted `X_val[i]` scanning `ptr`, `ptr+1`, … modulo `p_num_pipes`.
  - `X_rdy[i]` = grant[i]. The stage has no downstream backpressure, so an asserted valid is always granted when it wins.
- **Handshake:**
  - A transfer occurs on input i when `X_val[i] && X_rdy[i]` at a clock edge.
  - Non-granted inputs must hold their message and valid; the unit never drops a valid input.
  - `X_rdy` may depend combinationally on `X_val`. Senders must not make `X_val` depend on `X_rdy`.
- **Pointer update:**
  - On a transfer from input i, `ptr` ← (i+1) mod `p_num_pipes`.
  - With no transfer, `ptr` holds.
  - With `p_num_pipes`=1, `ptr` is constant 0.
- **Output register:** on a transfer, the pipeline register captures pc, seq_num, waddr, wdata and wen, and sets `complete_val`=1.
- **Write suppression:**
  - `rf_wen` = registered wen && (registered waddr ≠ 0) && `complete_val`.
  - An x0 write still produces `complete_val`=1.
- **Idle cycle:** with no transfer, `complete_val` and `rf_wen` go to 0 the next cycle. The data registers hold their previous values; their contents are don't-care while invalid.
- **Reset:**
  - Asynchronous: `complete_val`=0, `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `complete_pc`=0, `complete_seq_num`=0, `ptr`=0.
  - While `rst` is high, `X_rdy`=0.
  - Reset mid-stream discards the registered result; no write occurs.
- **Debug:** provides `trace()`, returning the granted input index (or blanks when idle), the destination register, and the data.

## Timing
- Latency is one cycle: input accepted at edge n → `rf_*` and `complete_*` valid during cycle n+1, and the RF commits at edge n+1.
- Throughput is one result per cycle in aggregate.
- Worst-case wait for any continuously valid input is `p_num_pipes`−1 cycles (starvation-free).
- Consecutive transfers produce back-to-back `complete_val`=1 with no bubble.
- In the first cycle after `rst` deasserts, `X_rdy` follows the arbitration immediately; input 0 has priority.

## Test plan
- **Single input:** input 0 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1 → next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `complete_val`=1, `complete_seq_num`=3; the cycle after, `complete_val`=0.
- **Contention fairness:** inputs 0 and 1 both valid continuously for 4 messages each (`p_num_pipes`=2) → grant order 0,1,0,1,…; every message is delivered exactly once and none starves.
- **x0 suppression:** waddr=0, wen=1, wdata=0x1234 → `rf_wen`=0, `complete_val`=1. Separately, waddr=7, wen=0 → `rf_wen`=0, `complete_val`=1.
- **Pointer hold:** input 1 is granted, then 2 idle cycles, then inputs 0 and 1 both valid → input 0 is granted first (ptr=0 held).
- **Async reset mid-stream:** assert `rst` between edges while `complete_val`=1 → `complete_val` and `rf_wen` drop to 0 immediately, with no RF write at the next edge. After release, input 0 wins a tie.
- **Random delays:** `p_num_pipes`=3, with multiplier-style sources using random valid gaps of 0–3 cycles → the multiset of (seq_num, waddr, wdata) at the output equals the inputs, and per-input order is preserved.
